div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/div_if.sv | 25 ++
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 131 +++++++++++++
 tb/tb_div_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
// Imported by div_step and div_unit.
package div_pkg;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [2:0] {
    DIV_IDLE  = 3'd0,
    DIV_CHECK = 3'd1,
    DIV_RUN   = 3'd2,
    DIV_FIX   = 3'd3,
    DIV_DONE  = 3'd4,
    DIV_ERR   = 3'd5
  } div_state_t;

endpackage

// File: rtl/div_if.sv
// Divide request/response bundle between the control unit (master) and div_unit (slave).
interface div_if #(
  parameter int WIDTH = 32
);

  logic             divControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hiDiv;
  logic [WIDTH-1:0] loDiv;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output divControl, a, b,
    input  hiDiv, loDiv, busy, done, div0
  );

  modport slave (
    input  divControl, a, b,
    output hiDiv, loDiv, busy, done, div0
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor
// and keep the difference when it does not go negative.
import div_pkg::*;

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the shifted value is below 2*divisor and the
  // borrow lands in the extra top bit.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_nxt = shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider: quotient to loDiv, remainder to hiDiv, div0 on zero divisor.
// Define DIV_SIGNED_EN for signed (div) semantics; otherwise unsigned (divu).
//
// state     | meaning
// ----------|--------------------------------------------------------------
// DIV_IDLE  | waiting for divControl; operands latched on accept
// DIV_CHECK | zero-divisor test, load rem=0 and quo=|a|
// DIV_RUN   | one restoring step per cycle, counter 0..31
// DIV_FIX   | apply result signs, register hiDiv/loDiv
// DIV_DONE  | done pulse, results valid
// DIV_ERR   | div0 pulse, results untouched
import div_pkg::*;

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  div_state_t             state_q;
  div_state_t             state_d;
  logic [DIV_CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       rem_q;
  logic [WIDTH-1:0]       quo_q;
  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;
  logic [WIDTH-1:0]       dvd_mag;
  logic [WIDTH-1:0]       dvs_mag;
  logic [WIDTH-1:0]       rem_nxt;
  logic [WIDTH-1:0]       quo_nxt;
  logic [WIDTH-1:0]       hi_fix;
  logic [WIDTH-1:0]       lo_fix;
  logic                   last_iter;

`ifdef DIV_SIGNED_EN
  // Magnitudes feed the unsigned core; 0x80000000 maps to itself, which is
  // still the right unsigned magnitude.
  assign dvd_mag = a_q[WIDTH-1] ? -a_q : a_q;
  assign dvs_mag = b_q[WIDTH-1] ? -b_q : b_q;
  assign lo_fix  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_q : quo_q;
  assign hi_fix  = a_q[WIDTH-1] ? -rem_q : rem_q;
`else
  assign dvd_mag = a_q;
  assign dvs_mag = b_q;
  assign lo_fix  = quo_q;
  assign hi_fix  = rem_q;
`endif

  assign last_iter = (cnt_q == DIV_CNT_W'(DIV_ITER - 1));

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_mag),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE:  if (bus.divControl) state_d = DIV_CHECK;
      DIV_CHECK: state_d = (b_q == '0) ? DIV_ERR : DIV_RUN;
      DIV_RUN:   if (last_iter) state_d = DIV_FIX;
      DIV_FIX:   state_d = DIV_DONE;
      DIV_DONE:  state_d = DIV_IDLE;
      DIV_ERR:   state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.divControl) begin
            a_q <= bus.a;
            b_q <= bus.b;
          end
        end
        DIV_CHECK: begin
          if (b_q != '0) begin
            rem_q <= '0;
            quo_q <= dvd_mag;
            cnt_q <= '0;
          end
        end
        DIV_RUN: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
        end
        DIV_FIX: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.hiDiv = hi_q;
  assign bus.loDiv = lo_q;
  assign bus.busy  = (state_q != DIV_IDLE);
  assign bus.done  = (state_q == DIV_DONE);
  assign bus.div0  = (state_q == DIV_ERR);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, busy/done/div0 framing, zero divisor,
// overflow, mid-run reset, ignored start during RUN. Expectations follow DIV_SIGNED_EN.
module tb_div_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a division right after an edge, then count cycles until done.
  // inj_k > 0 drives a stray divControl with other operands in cycle inj_k.
  task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int inj_k);
    int   k;
    logic busy_ok;
    logic div0_seen;
    bus.divControl = 1'b1;
    bus.a          = av;
    bus.b          = bv;
    tick();
    bus.divControl = 1'b0;
    k         = 1;
    busy_ok   = 1'b1;
    div0_seen = 1'b0;
    while (!bus.done && k < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.div0) div0_seen = 1'b1;
      if (k == inj_k) begin
        bus.divControl = 1'b1;
        bus.a          = 32'd50;
        bus.b          = 32'd5;
      end else begin
        bus.divControl = 1'b0;
      end
      tick();
      k++;
    end
    bus.divControl = 1'b0;
    chk({tag, " latency"}, k, 35);
    chk({tag, " busy"}, {31'd0, busy_ok & bus.busy}, 32'd1);
    chk({tag, " div0"}, {31'd0, div0_seen}, 32'd0);
    chk({tag, " lo"}, bus.loDiv, exp_lo);
    chk({tag, " hi"}, bus.hiDiv, exp_hi);
    tick();
    chk({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int extra;
    int k;
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.divControl = 1'b1;
    bus.a          = 32'd8;
    bus.b          = 32'd2;
    tick();
    tick();
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst div0", {31'd0, bus.div0}, 32'd0);
    chk("rst hi", bus.hiDiv, 32'd0);
    chk("rst lo", bus.loDiv, 32'd0);
    bus.divControl = 1'b0;
    reset          = 1'b0;
    tick();

    do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 0);
    // Restart in the IDLE cycle right after DONE.
`ifdef DIV_SIGNED_EN
    do_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
`else
    do_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 0);
`endif

    bus.divControl = 1'b1;
    bus.a          = 32'd5;
    bus.b          = 32'd0;
    tick();
    bus.divControl = 1'b0;
    chk("dz c1 div0", {31'd0, bus.div0}, 32'd0);
    chk("dz c1 busy", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("dz c2 div0", {31'd0, bus.div0}, 32'd1);
    chk("dz c2 done", {31'd0, bus.done}, 32'd0);
    tick();
    chk("dz c3 div0", {31'd0, bus.div0}, 32'd0);
    chk("dz c3 busy", {31'd0, bus.busy}, 32'd0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done || bus.div0) extra++;
      tick();
    end
    chk("dz no done", extra, 0);
`ifdef DIV_SIGNED_EN
    chk("dz lo kept", bus.loDiv, 32'hFFFF_FFFD);
    chk("dz hi kept", bus.hiDiv, 32'hFFFF_FFFF);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
`else
    chk("dz lo kept", bus.loDiv, 32'h7FFF_FFFC);
    chk("dz hi kept", bus.hiDiv, 32'd1);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
`endif
    do_div("7/100", 32'd7, 32'd100, 32'd0, 32'd7, 0);
    do_div("ff/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);

    // Reset ten cycles into RUN; ff/1 left loDiv nonzero.
    bus.divControl = 1'b1;
    bus.a          = 32'd1000;
    bus.b          = 32'd3;
    tick();
    bus.divControl = 1'b0;
    for (k = 1; k < 12; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst busy", {31'd0, bus.busy}, 32'd0);
    chk("mid rst done", {31'd0, bus.done}, 32'd0);
    chk("mid rst div0", {31'd0, bus.div0}, 32'd0);
    chk("mid rst hi", bus.hiDiv, 32'd0);
    chk("mid rst lo", bus.loDiv, 32'd0);
    tick();
    chk("mid rst idle", {31'd0, bus.busy}, 32'd0);
    do_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 0);

    do_div("inj 1000/7", 32'd1000, 32'd7, 32'd142, 32'd6, 5);
    extra = 0;
    for (int i = 0; i < 45; i++) begin
      if (bus.done || bus.busy) extra++;
      tick();
    end
    chk("inj no restart", extra, 0);
    chk("inj lo held", bus.loDiv, 32'd142);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
